syscon_rst_seq: RTL and testbench

//  Parametrised reset sequencer for the system controller. Filters a clock-tile

---
 rtl/syscon_rst_seq.sv | 149 ++++++++++++++
 tb/tb_syscon_rst_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/syscon_rst_seq.sv
// Lock-filtered reset sequencer: holds NUM_RST active-high resets, releases them staggered, re-sequences on lock loss.
// All outputs except wb_clk are registered; input effects appear one cycle later. No backpressure: requests outside RUN are dropped.
module syscon_rst_seq #(
  parameter int NUM_RST     = 4,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               locked_i,
  input  logic               sw_rst_req_i,
  input  logic [NUM_RST-1:0] sw_rst_mask_i,
  output logic               wb_clk,
  output logic [NUM_RST-1:0] rst_o,
  output logic               seq_done_o,
  output logic [1:0]         state_o,
  output logic [7:0]         rst_event_cnt_o
);

  localparam int FW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_RST - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SWRST   = 2'd3
  } state_t;

  state_t          state;
  logic [FW-1:0]   filt_cnt;
  logic            lock_ok;
  logic [HW-1:0]   hold_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [IW-1:0]   rel_idx;

  assign wb_clk  = clk;
  assign state_o = state;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // filt_cnt saturates at LOCK_FILTER-1, so lock_ok needs one more locked cycle on top of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      lock_ok  <= 1'b0;
    end else begin
      lock_ok <= locked_i && (filt_cnt == FILT_MAX);
      if (!locked_i)
        filt_cnt <= '0;
      else if (filt_cnt != FILT_MAX)
        filt_cnt <= filt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= HOLD;
      rst_o           <= '1;
      seq_done_o      <= 1'b0;
      rst_event_cnt_o <= 8'd0;
      hold_cnt        <= '0;
      gap_cnt         <= '0;
      rel_idx         <= '0;
    end else if (state != HOLD && !lock_ok) begin
      // Lock loss wins over any same-cycle software request.
      state           <= HOLD;
      rst_o           <= '1;
      seq_done_o      <= 1'b0;
      hold_cnt        <= '0;
      rst_event_cnt_o <= sat_inc(rst_event_cnt_o);
    end else begin
      case (state)
        HOLD: begin
          if (!lock_ok) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_MAX) begin
            hold_cnt <= '0;
            gap_cnt  <= '0;
            rel_idx  <= IW'(1);
            if (NUM_RST == 1) begin
              rst_o      <= '0;
              state      <= RUN;
              seq_done_o <= 1'b1;
            end else begin
              rst_o[0] <= 1'b0;
              state    <= RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (gap_cnt == GAP_MAX) begin
            gap_cnt        <= '0;
            rst_o[rel_idx] <= 1'b0;
            if (rel_idx == LAST_IDX) begin
              state      <= RUN;
              seq_done_o <= 1'b1;
            end else begin
              rel_idx <= rel_idx + 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        RUN: begin
          if (sw_rst_req_i && (sw_rst_mask_i != '0)) begin
            rst_o           <= sw_rst_mask_i;
            state           <= SWRST;
            seq_done_o      <= 1'b0;
            hold_cnt        <= '0;
            rst_event_cnt_o <= sat_inc(rst_event_cnt_o);
          end
        end

        SWRST: begin
          // hold_cnt doubles as the software pulse timer.
          if (hold_cnt == HOLD_MAX) begin
            hold_cnt   <= '0;
            rst_o      <= '0;
            state      <= RUN;
            seq_done_o <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state <= HOLD;
          rst_o <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syscon_rst_seq.sv
// Bench for syscon_rst_seq: timing vectors, corner sequences and random traffic against a time-based model.
module tb_syscon_rst_seq;
  localparam int N  = 4;
  localparam int LF = 8;
  localparam int HC = 16;
  localparam int SG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n  = 1'b0;
  logic         locked = 1'b0;
  logic         req    = 1'b0;
  logic [N-1:0] mask   = '0;

  logic         wb_clk, done;
  logic [N-1:0] rst;
  logic [1:0]   st;
  logic [7:0]   cnt;
  logic         wb_clk1, done1;
  logic [0:0]   rst1;
  logic [1:0]   st1;
  logic [7:0]   cnt1;

  syscon_rst_seq #(.NUM_RST(N), .LOCK_FILTER(LF), .HOLD_CYCLES(HC), .STAGE_GAP(SG)) dut (
    .clk(clk), .rst_n(rst_n), .locked_i(locked), .sw_rst_req_i(req), .sw_rst_mask_i(mask),
    .wb_clk(wb_clk), .rst_o(rst), .seq_done_o(done), .state_o(st), .rst_event_cnt_o(cnt));

  syscon_rst_seq #(.NUM_RST(1), .LOCK_FILTER(LF), .HOLD_CYCLES(HC), .STAGE_GAP(SG)) dut1 (
    .clk(clk), .rst_n(rst_n), .locked_i(locked), .sw_rst_req_i(req), .sw_rst_mask_i(mask[0:0]),
    .wb_clk(wb_clk1), .rst_o(rst1), .seq_done_o(done1), .state_o(st1), .rst_event_cnt_o(cnt1));

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  // Model: phase 0 = holding, 1 = sequencing/running (release times derived from t0), 2 = software pulse.
  int           m_phase, m_run, m_ok, m_t0, m_sw_end, m_cnt;
  logic [N-1:0] m_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic check_outputs(input string name, input logic [N-1:0] er, input logic [1:0] es,
                               input logic ed, input logic [7:0] ec);
    check({name, ".rst"},   32'(rst),  32'(er));
    check({name, ".state"}, 32'(st),   32'(es));
    check({name, ".done"},  32'(done), 32'(ed));
    check({name, ".cnt"},   32'(cnt),  32'(ec));
  endtask

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_ok = 0; m_t0 = 0; m_sw_end = 0; m_cnt = 0; m_mask = '0;
  endtask

  task automatic model_exp(output logic [N-1:0] er, output logic [1:0] es, output logic ed);
    er = '1; es = 2'd0; ed = 1'b0;
    if (m_phase == 1) begin
      for (int k = 0; k < N; k++) er[k] = (cyc < m_t0 + SG * k);
      ed = (cyc >= m_t0 + SG * (N - 1));
      es = ed ? 2'd2 : 2'd1;
    end else if (m_phase == 2) begin
      er = m_mask;
      es = 2'd3;
    end
  endtask

  task automatic model_step(input logic l, input logic r, input logic [N-1:0] m);
    bit ok;
    ok    = (m_run >= LF);
    m_run = l ? m_run + 1 : 0;
    if (m_phase != 0 && !ok) begin
      m_phase = 0; m_ok = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (m_phase == 0) begin
      if (ok) begin
        m_ok++;
        if (m_ok == HC) begin m_phase = 1; m_ok = 0; m_t0 = cyc + 1; end
      end else m_ok = 0;
    end else if (m_phase == 1) begin
      if (cyc >= m_t0 + SG * (N - 1) && r && m != '0) begin
        m_phase = 2; m_mask = m; m_sw_end = cyc + 1 + HC;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (cyc + 1 >= m_sw_end) begin
      m_phase = 1;
    end
  endtask

  task automatic run_cycle(input logic l, input logic r, input logic [N-1:0] m);
    logic [N-1:0] er; logic [1:0] es; logic ed;
    locked = l; req = r; mask = m;
    @(negedge clk);
    model_exp(er, es, ed);
    check_outputs("model", er, es, ed, 8'(m_cnt));
    model_step(l, r, m);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; locked = 1'b0; req = 1'b0; mask = '0;
    @(posedge clk); #1;
    check_outputs("reset", 4'b1111, 2'd0, 1'b0, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    cyc = 0;
    #1;
    model_reset();
  endtask

  typedef struct {
    int         low;
    int         at;
    logic [3:0] rst;
    logic [1:0] st;
    logic       dn;
    logic [7:0] cnt;
    logic       r1;
    logic [1:0] s1;
  } vec_t;

  vec_t vt[15];

  initial begin
    vt[0]  = '{-1,  0, 4'b1111, 2'd0, 1'b0, 8'd0, 1'b1, 2'd0};
    vt[1]  = '{-1, 23, 4'b1111, 2'd0, 1'b0, 8'd0, 1'b1, 2'd0};
    vt[2]  = '{-1, 24, 4'b1110, 2'd1, 1'b0, 8'd0, 1'b0, 2'd2};
    vt[3]  = '{-1, 27, 4'b1110, 2'd1, 1'b0, 8'd0, 1'b0, 2'd2};
    vt[4]  = '{-1, 28, 4'b1100, 2'd1, 1'b0, 8'd0, 1'b0, 2'd2};
    vt[5]  = '{-1, 32, 4'b1000, 2'd1, 1'b0, 8'd0, 1'b0, 2'd2};
    vt[6]  = '{-1, 35, 4'b1000, 2'd1, 1'b0, 8'd0, 1'b0, 2'd2};
    vt[7]  = '{-1, 36, 4'b0000, 2'd2, 1'b1, 8'd0, 1'b0, 2'd2};
    vt[8]  = '{ 5, 29, 4'b1111, 2'd0, 1'b0, 8'd0, 1'b1, 2'd0};
    vt[9]  = '{ 5, 30, 4'b1110, 2'd1, 1'b0, 8'd0, 1'b0, 2'd2};
    vt[10] = '{34, 35, 4'b1000, 2'd1, 1'b0, 8'd0, 1'b0, 2'd2};
    vt[11] = '{34, 36, 4'b1111, 2'd0, 1'b0, 8'd1, 1'b1, 2'd0};
    vt[12] = '{34, 58, 4'b1111, 2'd0, 1'b0, 8'd1, 1'b1, 2'd0};
    vt[13] = '{34, 59, 4'b1110, 2'd1, 1'b0, 8'd1, 1'b0, 2'd2};
    vt[14] = '{34, 71, 4'b0000, 2'd2, 1'b1, 8'd1, 1'b0, 2'd2};

    foreach (vt[i]) begin
      apply_reset();
      while (cyc < vt[i].at) run_cycle(cyc != vt[i].low, 1'b0, '0);
      check_outputs($sformatf("vec%0d", i), vt[i].rst, vt[i].st, vt[i].dn, vt[i].cnt);
      check($sformatf("vec%0d.rst1", i),   32'(rst1), 32'(vt[i].r1));
      check($sformatf("vec%0d.state1", i), 32'(st1),  32'(vt[i].s1));
    end

    // Software reset pulse, ignored requests, then a synchronous reset mid-pulse.
    apply_reset();
    while (cyc < 40) run_cycle(1'b1, 1'b0, '0);
    run_cycle(1'b1, 1'b1, 4'b0110);
    check_outputs("sw_assert", 4'b0110, 2'd3, 1'b0, 8'd1);
    while (cyc < 45) run_cycle(1'b1, 1'b0, '0);
    run_cycle(1'b1, 1'b1, 4'b1001);
    while (cyc < 56) run_cycle(1'b1, 1'b0, '0);
    check_outputs("sw_last", 4'b0110, 2'd3, 1'b0, 8'd1);
    run_cycle(1'b1, 1'b0, '0);
    check_outputs("sw_release", 4'b0000, 2'd2, 1'b1, 8'd1);
    run_cycle(1'b1, 1'b1, '0);
    check_outputs("sw_mask0", 4'b0000, 2'd2, 1'b1, 8'd1);
    run_cycle(1'b1, 1'b0, '0);
    run_cycle(1'b1, 1'b1, 4'b1000);
    check_outputs("sw_again", 4'b1000, 2'd3, 1'b0, 8'd2);
    check("wb_clk_hi", 32'(wb_clk), 32'd1);

    apply_reset();
    while (cyc < 24) run_cycle(1'b1, 1'b0, '0);
    check_outputs("restart_rel0", 4'b1110, 2'd1, 1'b0, 8'd0);
    while (cyc < 40) run_cycle(1'b1, 1'b0, '0);
    check_outputs("restart_run", 4'b0000, 2'd2, 1'b1, 8'd0);
    run_cycle(1'b0, 1'b0, '0);
    run_cycle(1'b1, 1'b1, 4'b1111);
    check_outputs("loss_vs_sw", 4'b1111, 2'd0, 1'b0, 8'd1);

    apply_reset();
    for (int i = 0; i < 3000; i++)
      run_cycle($urandom_range(0, 63) != 0, $urandom_range(0, 9) == 0, N'($urandom_range(0, 15)));

    // Repeated lock loss drives the event counter into saturation.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      run_cycle(1'b0, 1'b0, '0);
      for (int j = 0; j < 25; j++) run_cycle(1'b1, 1'b0, '0);
    end
    check("cnt_sat", 32'(cnt), 32'd255);

    @(negedge clk);
    check("wb_clk_lo", 32'(wb_clk), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
